// File: rtl/shift_register_arb.sv
// Round-robin arbiter feeding an external shift_register delay line.
// Tracks {valid, requester} per stage so the line's output word can be identified.
//
// Ports:
//   iClk, iRstN            clock, async active-low reset
//   iReq[NREQ]             per-requester request
//   iData[NREQ*BITWIDTH]   requester words, slice k = requester k
//   iStall                 freezes the delay line
//   iFlush                 discard all in-flight words
//   oGnt[NREQ]             one-hot grant (combinational)
//   oSrEn/oSrClr/oSrData   drive shift_register iEn/iClr/iData
//   oOutValid/oOutTag      shift_register oData carries an accepted word / its requester
//   oCount                 accepted words still in flight
//   oBusy                  FSM not in IDLE
module shift_register_arb #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 8,
    parameter int NREQ     = 4,
    localparam int TW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic [NREQ-1:0]          iReq,
    input  logic [NREQ*BITWIDTH-1:0] iData,
    input  logic                     iStall,
    input  logic                     iFlush,
    output logic [NREQ-1:0]          oGnt,
    output logic                     oSrEn,
    output logic                     oSrClr,
    output logic [BITWIDTH-1:0]      oSrData,
    output logic                     oOutValid,
    output logic [TW-1:0]            oOutTag,
    output logic [CW-1:0]            oCount,
    output logic                     oBusy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t        state;
    logic          busy_q;
    logic          clr_q;

    logic [TW-1:0] ptr;
    logic [TW-1:0] gidx;
    logic [TW-1:0] cand;
    logic [TW-1:0] nxt_ptr;
    logic          found;
    logic          gnt_ok;
    logic          accept;
    logic          shift_out;
    logic          flush_start;
    logic          do_clear;

    logic          tag_v [DEPTH];
    logic [TW-1:0] tag_i [DEPTH];
    logic [CW-1:0] count;

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = TW'((int'(ptr) + i) % NREQ);
            if (!found && iReq[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
    end

    always_comb begin
        if (int'(gidx) == NREQ - 1) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = gidx + TW'(1);
        end
    end

    // Grants and line enable are gated by reset so they read zero while
    // iRstN is low, regardless of the request inputs.
    always_comb begin
        gnt_ok      = iRstN && (state != FLUSH) && !iStall && !iFlush;
        accept      = found && gnt_ok;
        oSrEn       = iRstN && (state != FLUSH) && !iStall;
        shift_out   = oSrEn && tag_v[DEPTH-1];
        flush_start = iFlush && (state != FLUSH);
        do_clear    = flush_start || (state == FLUSH);
    end

    always_comb begin
        oGnt = '0;
        if (accept) begin
            oGnt[gidx] = 1'b1;
        end
    end

    always_comb begin
        oSrData = '0;
        if (accept) begin
            oSrData = iData[int'(gidx)*BITWIDTH +: BITWIDTH];
        end
    end

    // Control FSM; oBusy and oSrClr are registered alongside the state.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iFlush) begin
                        state  <= FLUSH;
                        busy_q <= 1'b1;
                        clr_q  <= 1'b1;
                    end else if (|iReq) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        clr_q  <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                        clr_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (iFlush) begin
                        state  <= FLUSH;
                        busy_q <= 1'b1;
                        clr_q  <= 1'b1;
                    end else if (count == '0 && !accept) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        clr_q  <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                        clr_q  <= 1'b0;
                    end
                end
                FLUSH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    clr_q  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    clr_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag line mirrors the external delay line stage for stage. It is
    // cleared on the edge entering FLUSH so the tags are already empty
    // while the external line is being cleared.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_v[i] <= 1'b0;
                tag_i[i] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= nxt_ptr;
            end
            if (do_clear) begin
                count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    tag_v[i] <= 1'b0;
                    tag_i[i] <= '0;
                end
            end else if (oSrEn) begin
                tag_v[0] <= accept;
                tag_i[0] <= accept ? gidx : '0;
                for (int i = 1; i < DEPTH; i++) begin
                    tag_v[i] <= tag_v[i-1];
                    tag_i[i] <= tag_i[i-1];
                end
                // A full line always shifts a valid word out as it
                // accepts, so count cannot pass DEPTH.
                if (accept && !shift_out) begin
                    count <= count + CW'(1);
                end else if (!accept && shift_out) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_comb begin
        oOutValid = tag_v[DEPTH-1];
        oOutTag   = tag_i[DEPTH-1];
        oCount    = count;
        oBusy     = busy_q;
        oSrClr    = clr_q;
    end

endmodule

// File: tb/tb_shift_register_arb.sv
// Randomized scoreboard bench for shift_register_arb with a stand-in shift_register.
// Expected words are queued at grant time and matched when the delay line presents them.
module tb_shift_register_arb;

    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int NREQ  = 4;
    localparam int TW    = $clog2(NREQ);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    logic                 iClk;
    logic                 iRstN;
    logic [NREQ-1:0]      iReq;
    logic [NREQ*BW-1:0]   iData;
    logic                 iStall;
    logic                 iFlush;
    logic [NREQ-1:0]      oGnt;
    logic                 oSrEn;
    logic                 oSrClr;
    logic [BW-1:0]        oSrData;
    logic                 oOutValid;
    logic [TW-1:0]        oOutTag;
    logic [CW-1:0]        oCount;
    logic                 oBusy;

    shift_register_arb #(
        .BITWIDTH(BW),
        .DEPTH   (DEPTH),
        .NREQ    (NREQ)
    ) dut (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iReq     (iReq),
        .iData    (iData),
        .iStall   (iStall),
        .iFlush   (iFlush),
        .oGnt     (oGnt),
        .oSrEn    (oSrEn),
        .oSrClr   (oSrClr),
        .oSrData  (oSrData),
        .oOutValid(oOutValid),
        .oOutTag  (oOutTag),
        .oCount   (oCount),
        .oBusy    (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Stand-in for the driven shift_register.
    logic [BW-1:0] sr [DEPTH];
    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (oSrClr) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (oSrEn) begin
            for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= oSrData;
        end
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [BW-1:0] data;
        int            shifts;
    } item_t;

    item_t exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    int    st    = M_IDLE;
    int    ptr_m = 0;
    int    cyc   = 0;
    bit    p_rst = 1'b1;
    bit    p_en  = 1'b0;
    bit    p_acc = 1'b0;
    bit    p_fl  = 1'b0;
    int    p_st  = M_IDLE;
    item_t p_item;
    logic [NREQ-1:0] gnt_seen;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h",
                     nm, cyc, act, exp_v);
        end
    endtask

    // One clock cycle: apply the previous cycle's effects to the model,
    // drive new inputs, compare combinational and registered outputs.
    task automatic cycle(input logic [NREQ-1:0] req,
                         input logic [NREQ*BW-1:0] data,
                         input bit stall, input bit flush, input bit rst);
        int g;
        int j;
        logic [NREQ-1:0] e_gnt;
        logic [BW-1:0]   e_data;
        bit e_en;
        bit e_clr;
        bit e_busy;
        @(posedge iClk);
        if (!p_rst) begin
            if (p_fl) begin
                exp_q.delete();
            end else if (p_en) begin
                for (int k = 0; k < exp_q.size(); k++)
                    exp_q[k].shifts = exp_q[k].shifts + 1;
                if (p_acc) exp_q.push_back(p_item);
            end
            st = p_st;
        end
        #1;
        iReq   = req;
        iData  = data;
        iStall = stall;
        iFlush = flush;
        iRstN  = !rst;
        if (rst) begin
            exp_q.delete();
            ptr_m = 0;
            st    = M_IDLE;
        end
        #1;
        g = -1;
        if (!rst && st != M_FLUSH && !stall && !flush) begin
            for (int i = 0; i < NREQ; i++) begin
                j = (ptr_m + i) % NREQ;
                if (g < 0 && req[j]) g = j;
            end
        end
        e_gnt  = '0;
        e_data = '0;
        if (g >= 0) begin
            e_gnt[g] = 1'b1;
            e_data   = data[g*BW +: BW];
        end
        e_en   = !rst && st != M_FLUSH && !stall;
        e_clr  = !rst && st == M_FLUSH;
        e_busy = !rst && st != M_IDLE;
        gnt_seen = oGnt;
        chk("gnt", oGnt, e_gnt);
        chk("sr_en", oSrEn, e_en);
        chk("sr_clr", oSrClr, e_clr);
        chk("sr_data", oSrData, e_data);
        chk("count", oCount, exp_q.size());
        chk("busy", oBusy, e_busy);
        if (rst) begin
            chk("rst_valid", oOutValid, 0);
            chk("rst_tag", oOutTag, 0);
        end
        p_rst  = rst;
        p_en   = e_en;
        p_acc  = (g >= 0);
        p_item = '{tag: TW'(g), data: e_data, shifts: 1};
        p_fl   = !rst && flush && st != M_FLUSH;
        if (rst) p_st = M_IDLE;
        else if (st == M_IDLE)
            p_st = flush ? M_FLUSH : ((|req) ? M_RUN : M_IDLE);
        else if (st == M_RUN)
            p_st = flush ? M_FLUSH
                 : ((exp_q.size() == 0 && g < 0) ? M_IDLE : M_RUN);
        else p_st = M_IDLE;
        if (g >= 0) ptr_m = (g + 1) % NREQ;
        cyc++;
    endtask

    function automatic logic [NREQ*BW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: the oldest queued word is due once it has seen DEPTH shifts;
    // it leaves the queue on the cycle the line shifts it out.
    initial begin
        forever begin
            @(negedge iClk);
            if (exp_q.size() > 0 && exp_q[0].shifts == DEPTH) begin
                chk("out_valid", oOutValid, 1);
                chk("out_tag", oOutTag, exp_q[0].tag);
                chk("out_data", sr[DEPTH-1], exp_q[0].data);
                if (p_en && !p_rst) void'(exp_q.pop_front());
            end else begin
                chk("out_valid", oOutValid, 0);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 0, 0, 0);
    endtask

    initial begin
        logic [NREQ*BW-1:0] d;
        bit seen;
        iRstN  = 1'b0;
        iReq   = '0;
        iData  = '0;
        iStall = 1'b0;
        iFlush = 1'b0;

        cycle(4'hF, rnd_data(), 0, 0, 1);
        cycle(4'hF, rnd_data(), 1, 1, 1);

        // Single word through the line.
        d = '0;
        d[2*BW +: BW] = 32'hA5A5_0001;
        cycle(4'b0100, d, 0, 0, 0);
        chk("single_gnt", gnt_seen, 4'b0100);
        idle(8);
        chk("single_valid", oOutValid, 1);
        chk("single_tag", oOutTag, 2);
        chk("single_data", sr[DEPTH-1], 32'hA5A5_0001);
        idle(4);

        // Round-robin order from reset, then a full line.
        cycle('0, '0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(4'hF, rnd_data(), 0, 0, 0);
            chk("rr_order", gnt_seen, 1 << (i % 4));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(4'hF, rnd_data(), 0, 0, 0);
            chk("rr_full", oCount, DEPTH);
        end
        idle(12);

        // Stall stretches latency by the stalled cycles.
        cycle(4'b0001, rnd_data(), 0, 0, 0);
        seen = 1'b0;
        for (int t = 1; t <= 20 && !seen; t++) begin
            cycle('0, '0, (t >= 3 && t <= 5), 0, 0);
            if (t >= 3 && t <= 5) chk("stall_cnt", oCount, 1);
            if (oOutValid) begin
                seen = 1'b1;
                chk("stall_lat", t, 11);
            end
        end
        chk("stall_seen", seen, 1);
        idle(4);

        // Flush with five words in flight.
        for (int i = 0; i < 5; i++)
            cycle(NREQ'($urandom_range(1, 15)), rnd_data(), 0, 0, 0);
        cycle('0, '0, 0, 1, 0);
        chk("flush_pre_cnt", oCount, 5);
        idle(1);
        chk("flush_clr", oSrClr, 1);
        chk("flush_cnt", oCount, 0);
        chk("flush_valid", oOutValid, 0);
        idle(1);
        chk("flush_clr_off", oSrClr, 0);
        chk("flush_idle", oBusy, 0);

        // Flush together with stall, then flush held.
        cycle(4'hF, rnd_data(), 1, 1, 0);
        chk("fs_gnt", gnt_seen, 0);
        chk("fs_en", oSrEn, 0);
        cycle(4'hF, rnd_data(), 1, 0, 0);
        chk("fs_clr", oSrClr, 1);
        chk("fs_en2", oSrEn, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(4'hF, rnd_data(), 0, 1, 0);
            chk("hold_gnt", gnt_seen, 0);
        end
        idle(3);

        // Random run with occasional stall, flush and mid-stream reset.
        for (int i = 0; i < 100; i++) begin
            cycle(NREQ'($urandom_range(0, 15)), rnd_data(),
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 99) < 4));
        end
        idle(DEPTH + 6);
        chk("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
